kernel_seq_ctrl: RTL and testbench

//  Parametrised successor of the single-kernel convolution controller. Collects NUM_KERNELS

---
 rtl/kernel_seq_ctrl_pkg.sv | 25 ++
 rtl/kernel_seq_ctrl_run_watchdog.sv | 45 ++++
 rtl/kernel_seq_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_kernel_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_seq_ctrl_pkg.sv
// kernel_seq_ctrl_pkg
//   Shared definitions for the multi-kernel convolution sequencer:
//   the top-level FSM code that enables the sequencer, the phase
//   encoding of the sequencer FSM, and a width helper for counters
//   that must stay at least one bit wide.
package kernel_seq_ctrl_pkg;

  // Top-level FSM state code in which the sequencer is allowed to run.
  localparam int BONUS = 5;

  typedef enum logic [2:0] {
    KS_IDLE  = 3'd0,
    KS_LOAD  = 3'd1,
    KS_RUN   = 3'd2,
    KS_PRINT = 3'd3,
    KS_DONE  = 3'd4
  } ks_phase_e;

  // $clog2 that never returns zero, so degenerate parameter choices
  // (one kernel, 1x1 kernel, watchdog disabled) still give legal vectors.
  function automatic int clog2Min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/kernel_seq_ctrl_run_watchdog.sv
// run_watchdog
//   Saturating cycle counter used to bound how long an engine handshake
//   may stay outstanding. Counting starts from zero after clr_i and
//   advances on every cycle with en_i high.
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   clr_i      synchronous clear of the count (wins over en_i)
//   en_i       count this cycle
//   limit_i    expiry threshold; zero disables expiry
//   expired_o  count has reached limit_i (combinational from the count)
module run_watchdog #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear has priority; otherwise count up and stick at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (limit_i != '0) && (count_q >= limit_i);

endmodule

// File: rtl/kernel_seq_ctrl.sv
// kernel_seq_ctrl
//   Sequencer for the convolution datapath. While the top-level FSM sits
//   in ACTIVE_STATE it loads NUM_KERNELS coefficient sets of KDIM*KDIM
//   words from the decoder, and for each set runs the conv engine and
//   then asks the printer for a result dump. A watchdog aborts a RUN
//   that never finishes and raises a sticky error.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   state_i         top-level FSM state; anything but ACTIVE_STATE idles us
//   dec_valid_i     decoder strobe, dec_data_i valid
//   dec_data_i      coefficient word from the decoder
//   run_done_i      conv engine finished
//   print_done_i    printer finished the current request
//   start_run_o     level, engine runs while high
//   kernel_we_o     one-cycle coefficient write strobe
//   kernel_sel_o    target kernel bank of the write
//   kernel_idx_o    coefficient index of the write
//   kernel_data_o   coefficient value of the write
//   print_req_o     level, held until print_done_i
//   busy_o          loading, running or printing
//   done_o          all kernels handled
//   err_o           sticky watchdog error
module kernel_seq_ctrl
  import kernel_seq_ctrl_pkg::*;
#(
  parameter int                 DATA_W       = 32,
  parameter int                 KDIM         = 3,
  parameter int                 NUM_KERNELS  = 2,
  parameter int                 STATE_W      = 4,
  parameter logic [STATE_W-1:0] ACTIVE_STATE = STATE_W'(BONUS),
  parameter int                 TIMEOUT_CYC  = 1000000,
  localparam int                KLEN         = KDIM * KDIM,
  localparam int                SEL_W        = clog2Min1(NUM_KERNELS),
  localparam int                IDX_W        = clog2Min1(KLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state_i,
  input  logic               dec_valid_i,
  input  logic [DATA_W-1:0]  dec_data_i,
  input  logic               run_done_i,
  input  logic               print_done_i,
  output logic               start_run_o,
  output logic               kernel_we_o,
  output logic [SEL_W-1:0]   kernel_sel_o,
  output logic [IDX_W-1:0]   kernel_idx_o,
  output logic [DATA_W-1:0]  kernel_data_o,
  output logic               print_req_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int WD_W = clog2Min1(TIMEOUT_CYC + 1);

  ks_phase_e          phase_q, phase_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   kSel_q, kSel_d;
  logic               startRun_q, startRun_d;
  logic               kernelWe_q, kernelWe_d;
  logic [SEL_W-1:0]   kernelSel_q, kernelSel_d;
  logic [IDX_W-1:0]   kernelIdx_q, kernelIdx_d;
  logic [DATA_W-1:0]  kernelData_q, kernelData_d;
  logic               printReq_q, printReq_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic isActive;
  logic lastBeat;
  logic lastKernel;
  logic inRun;
  logic wdExpired;

  assign isActive   = (state_i == ACTIVE_STATE);
  assign lastBeat   = (cnt_q == IDX_W'(KLEN - 1));
  assign lastKernel = (kSel_q == SEL_W'(NUM_KERNELS - 1));
  assign inRun      = (phase_q == KS_RUN);

  // The watchdog only counts while in RUN and is held at zero otherwise,
  // so each kernel's RUN starts with a fresh budget.
  run_watchdog #(
    .W(WD_W)
  ) uWatchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!inRun),
    .en_i      (inRun),
    .limit_i   (WD_W'(TIMEOUT_CYC)),
    .expired_o (wdExpired)
  );

  // Next-state and next-output logic. Every output is computed here as a
  // _d value and registered below. Leaving ACTIVE_STATE is checked first
  // so it beats any handshake arriving in the same cycle. run_done is only
  // honoured once start_run is actually high, which guarantees exactly one
  // start_run rising edge per kernel.
  always_comb begin
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    kSel_d       = kSel_q;
    startRun_d   = 1'b0;
    kernelWe_d   = 1'b0;
    kernelSel_d  = kernelSel_q;
    kernelIdx_d  = kernelIdx_q;
    kernelData_d = kernelData_q;
    printReq_d   = 1'b0;
    err_d        = err_q;

    if (!isActive) begin
      phase_d      = KS_IDLE;
      cnt_d        = '0;
      kSel_d       = '0;
      kernelSel_d  = '0;
      kernelIdx_d  = '0;
      kernelData_d = '0;
      err_d        = 1'b0;
    end else begin
      case (phase_q)
        KS_IDLE: begin
          phase_d = KS_LOAD;
          cnt_d   = '0;
          kSel_d  = '0;
        end
        KS_LOAD: begin
          if (dec_valid_i) begin
            kernelWe_d   = 1'b1;
            kernelIdx_d  = cnt_q;
            kernelSel_d  = kSel_q;
            kernelData_d = dec_data_i;
            if (lastBeat) begin
              cnt_d   = '0;
              phase_d = KS_RUN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        KS_RUN: begin
          if (run_done_i && startRun_q) begin
            printReq_d = 1'b1;
            phase_d    = KS_PRINT;
          end else if (wdExpired) begin
            err_d   = 1'b1;
            phase_d = KS_DONE;
          end else begin
            startRun_d = 1'b1;
          end
        end
        KS_PRINT: begin
          if (print_done_i) begin
            if (lastKernel) begin
              phase_d = KS_DONE;
            end else begin
              kSel_d  = kSel_q + 1'b1;
              cnt_d   = '0;
              phase_d = KS_LOAD;
            end
          end else begin
            printReq_d = 1'b1;
          end
        end
        KS_DONE: begin
          phase_d = KS_DONE;
        end
        default: begin
          phase_d = KS_IDLE;
        end
      endcase
    end

    busy_d = (phase_d == KS_LOAD) || (phase_d == KS_RUN) || (phase_d == KS_PRINT);
    done_d = (phase_d == KS_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q      <= KS_IDLE;
      cnt_q        <= '0;
      kSel_q       <= '0;
      startRun_q   <= 1'b0;
      kernelWe_q   <= 1'b0;
      kernelSel_q  <= '0;
      kernelIdx_q  <= '0;
      kernelData_q <= '0;
      printReq_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      kSel_q       <= kSel_d;
      startRun_q   <= startRun_d;
      kernelWe_q   <= kernelWe_d;
      kernelSel_q  <= kernelSel_d;
      kernelIdx_q  <= kernelIdx_d;
      kernelData_q <= kernelData_d;
      printReq_q   <= printReq_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign start_run_o   = startRun_q;
  assign kernel_we_o   = kernelWe_q;
  assign kernel_sel_o  = kernelSel_q;
  assign kernel_idx_o  = kernelIdx_q;
  assign kernel_data_o = kernelData_q;
  assign print_req_o   = printReq_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_kernel_seq_ctrl.sv
// tb_kernel_seq_ctrl
//   Self-checking bench for kernel_seq_ctrl with two 3x3 kernels and a
//   16-cycle watchdog. Coefficients and inter-word gaps are random; the
//   expected coefficient writes are built as a list of (kernel, index,
//   word) tuples from the words actually sent during loading, and the
//   handshake behaviour is checked against fixed latencies.
module tb_kernel_seq_ctrl;

  localparam int DW  = 32;
  localparam int KD  = 3;
  localparam int NK  = 2;
  localparam int SW  = 4;
  localparam int TMO = 16;
  localparam int KL  = KD * KD;
  localparam logic [SW-1:0] ACT = 4'd5;
  localparam logic [SW-1:0] OFF = 4'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] state;
  logic          decValid;
  logic [DW-1:0] decData;
  logic          runDone;
  logic          printDone;
  logic          startRun;
  logic          kernelWe;
  logic [0:0]    kernelSel;
  logic [3:0]    kernelIdx;
  logic [DW-1:0] kernelData;
  logic          printReq;
  logic          busy;
  logic          done;
  logic          err;
  logic [42:0]   allOuts;

  int compared   = 0;
  int mismatched = 0;
  int startRises = 0;
  int printRises = 0;
  int overlaps   = 0;
  logic prevStart = 1'b0;
  logic prevPrint = 1'b0;

  // Write tuples {sel, idx, data}
  logic [36:0] obsWrites[$];
  logic [36:0] expWrites[$];

  always #5 clk = ~clk;

  kernel_seq_ctrl #(
    .DATA_W       (DW),
    .KDIM         (KD),
    .NUM_KERNELS  (NK),
    .STATE_W      (SW),
    .ACTIVE_STATE (ACT),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .state_i       (state),
    .dec_valid_i   (decValid),
    .dec_data_i    (decData),
    .run_done_i    (runDone),
    .print_done_i  (printDone),
    .start_run_o   (startRun),
    .kernel_we_o   (kernelWe),
    .kernel_sel_o  (kernelSel),
    .kernel_idx_o  (kernelIdx),
    .kernel_data_o (kernelData),
    .print_req_o   (printReq),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  assign allOuts = {startRun, kernelWe, kernelSel, kernelIdx, kernelData,
                    printReq, busy, done, err};

  // Observe the DUT on the falling edge: collect writes, count rising
  // edges of the two handshake levels and note any write that overlaps them.
  always @(negedge clk) begin
    if (kernelWe) obsWrites.push_back({kernelSel, kernelIdx, kernelData});
    if (startRun && !prevStart) startRises++;
    if (printReq && !prevPrint) printRises++;
    if (kernelWe && (startRun || printReq)) overlaps++;
    prevStart = startRun;
    prevPrint = printReq;
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge; they are sampled
  // by the following edge. On return the outputs reflect the edge waited on.
  task automatic applyStimulus(input logic [SW-1:0] st, input logic dv,
                               input logic [DW-1:0] dd, input logic rd,
                               input logic pd);
    @(posedge clk);
    #1;
    state     = st;
    decValid  = dv;
    decData   = dd;
    runDone   = rd;
    printDone = pd;
  endtask

  // Send one kernel's worth of words with random gaps and check the
  // final-write / start_run hand-over latency.
  task automatic loadKernel(input int k);
    logic [DW-1:0] w;
    int gap;
    for (int i = 0; i < KL; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) applyStimulus(ACT, 1'b0, $urandom, 1'b0, 1'b0);
      w = $urandom;
      applyStimulus(ACT, 1'b1, w, 1'b0, 1'b0);
      expWrites.push_back({k[0], i[3:0], w});
    end
    applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("final_we", kernelWe, 1);
    checkOutput("final_idx", kernelIdx, KL - 1);
    checkOutput("no_start_during_we", startRun, 0);
    applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("start_after_we", startRun, 1);
    checkOutput("we_dropped", kernelWe, 0);
    checkOutput("busy_in_run", busy, 1);
  endtask

  // Ignored strobes during RUN and PRINT, then the two handshakes.
  task automatic runAndPrint(input int k);
    repeat ($urandom_range(1, 3)) applyStimulus(ACT, 1'b1, $urandom, 1'b0, 1'b0);
    applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("run_idx_held", kernelIdx, KL - 1);
    checkOutput("run_sel_held", kernelSel, k);
    checkOutput("run_still_started", startRun, 1);
    applyStimulus(ACT, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(ACT, 1'b1, $urandom, 1'b0, 1'b0);
    checkOutput("print_req_after_done", printReq, 1);
    checkOutput("start_dropped", startRun, 0);
    repeat ($urandom_range(0, 2)) applyStimulus(ACT, 1'b1, $urandom, 1'b0, 1'b0);
    applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("print_req_held", printReq, 1);
    applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("print_req_dropped", printReq, 0);
    checkOutput("print_sel_held", kernelSel, k);
    if (k == NK - 1) begin
      checkOutput("done_after_last", done, 1);
      checkOutput("busy_after_last", busy, 0);
    end else begin
      checkOutput("not_done_mid", done, 0);
      checkOutput("busy_mid", busy, 1);
    end
  endtask

  initial begin
    int sBase;
    int pBase;
    int highCycles;
    int nCmp;

    rst = 1'b1;
    state = OFF;
    decValid = 1'b0;
    decData = '0;
    runDone = 1'b0;
    printDone = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", allOuts, 0);
    rst = 1'b0;

    // Full activations with two kernels each, then leave ACTIVE.
    for (int r = 0; r < 2; r++) begin
      sBase = startRises;
      pBase = printRises;
      applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < NK; k++) begin
        loadKernel(k);
        runAndPrint(k);
      end
      checkOutput("full_start_pulses", startRises - sBase, NK);
      checkOutput("full_print_pulses", printRises - pBase, NK);
      checkOutput("full_err", err, 0);
      repeat (3) applyStimulus(ACT, 1'b1, $urandom, 1'b1, 1'b1);
      applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("done_sticks", done, 1);
      checkOutput("done_no_write", kernelWe, 0);
      checkOutput("done_no_print", printReq, 0);
      applyStimulus(OFF, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(OFF, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("exit_clears_all", allOuts, 0);
    end

    // Partial load, exit with a coincident strobe, re-enter at idx 0 sel 0.
    applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] w;
      w = $urandom;
      applyStimulus(ACT, 1'b1, w, 1'b0, 1'b0);
      expWrites.push_back({1'b0, i[3:0], w});
    end
    applyStimulus(OFF, 1'b1, $urandom, 1'b1, 1'b1);
    applyStimulus(OFF, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("partial_exit_clears", allOuts, 0);
    applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b0);

    // Re-entry load, then withhold run_done until the watchdog fires.
    sBase = startRises;
    pBase = printRises;
    loadKernel(0);
    highCycles = 1;
    for (int c = 0; c < 40 && startRun; c++) begin
      applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b0);
      if (startRun) highCycles++;
    end
    checkOutput("timeout_run_cycles", highCycles, TMO);
    checkOutput("timeout_err", err, 1);
    checkOutput("timeout_done", done, 1);
    checkOutput("timeout_busy", busy, 0);
    repeat (3) applyStimulus(ACT, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("timeout_err_sticky", err, 1);
    checkOutput("timeout_no_print", printRises - pBase, 0);
    checkOutput("timeout_one_start", startRises - sBase, 1);
    applyStimulus(OFF, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(OFF, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("exit_clears_err", allOuts, 0);

    // run_done arriving together with the exit must not raise print_req.
    pBase = printRises;
    applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b0);
    loadKernel(0);
    applyStimulus(OFF, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(OFF, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("exit_beats_run_done", allOuts, 0);
    applyStimulus(OFF, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("exit_no_print_pulse", printRises - pBase, 0);

    // Asynchronous reset in the middle of PRINT.
    applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b0);
    loadKernel(0);
    applyStimulus(ACT, 1'b0, '0, 1'b1, 1'b0);
    applyStimulus(ACT, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("pre_reset_print", printReq, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_clears", allOuts, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    state = OFF;
    runDone = 1'b0;
    applyStimulus(OFF, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("after_reset_idle", allOuts, 0);

    // Compare every observed coefficient write against the expected list.
    checkOutput("write_count", obsWrites.size(), expWrites.size());
    nCmp = (obsWrites.size() < expWrites.size()) ? obsWrites.size() : expWrites.size();
    for (int i = 0; i < nCmp; i++) begin
      checkOutput($sformatf("write_%0d", i), obsWrites[i], expWrites[i]);
    end
    checkOutput("write_overlaps_handshake", overlaps, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
